// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state type for the I/D cache memory arbiter.
package mem_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // One-hot grant vector {D,I}; all-zero means nobody owns the port
  localparam logic [1:0] ARB_OWNER_NONE = 2'b00;
  localparam logic [1:0] ARB_OWNER_I    = 2'b01;
  localparam logic [1:0] ARB_OWNER_D    = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last_d,
  output logic [1:0] grant
);

  always_comb begin
    grant = ARB_OWNER_NONE;
    if (req_d && (!req_i || !last_d)) begin
      grant = ARB_OWNER_D;
    end else if (req_i) begin
      grant = ARB_OWNER_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the BRAM burst port between icache and dcache, one burst per grant,
// with a one-cycle dead gap after every burst.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH_P = DATA_WIDTH,
  parameter int ADDR_WIDTH_P = ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH_P-1:0] i_mem_addr,
  input  logic                    i_mem_enable,
  output logic [DATA_WIDTH_P-1:0] i_mem_read,
  output logic                    i_mem_read_valid,
  output logic                    i_mem_last,
  input  logic [ADDR_WIDTH_P-1:0] d_mem_addr,
  input  logic                    d_mem_enable,
  input  logic                    d_mem_rw,
  input  logic [DATA_WIDTH_P-1:0] d_mem_write,
  output logic [DATA_WIDTH_P-1:0] d_mem_read,
  output logic                    d_mem_read_valid,
  output logic                    d_mem_write_req,
  output logic                    d_mem_last,
  output logic [ADDR_WIDTH_P-1:0] mem_addr,
  output logic                    mem_enable,
  output logic                    mem_rw,
  output logic [DATA_WIDTH_P-1:0] mem_write,
  input  logic [DATA_WIDTH_P-1:0] mem_read,
  input  logic                    mem_read_valid,
  input  logic                    mem_write_req,
  input  logic                    mem_last,
  output logic [1:0]              owner
);

  arb_state_t              state, state_next;
  logic [1:0]              owner_q, owner_next;
  logic                    last_d, last_d_next;
  logic [ADDR_WIDTH_P-1:0] addr_q, addr_next;
  logic                    rw_q, rw_next;
  logic [1:0]              pick;
  logic                    owner_enable;
  logic                    granted, own_i, own_d;

  rr_pick2 u_pick (
    .req_i  (i_mem_enable),
    .req_d  (d_mem_enable),
    .last_d (last_d),
    .grant  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      owner_q <= ARB_OWNER_NONE;
      last_d  <= 1'b0;
      addr_q  <= '0;
      rw_q    <= MEM_READ;
    end else begin
      state   <= state_next;
      owner_q <= owner_next;
      last_d  <= last_d_next;
      addr_q  <= addr_next;
      rw_q    <= rw_next;
    end
  end

  assign owner_enable = (owner_q == ARB_OWNER_D) ? d_mem_enable : i_mem_enable;

  // The gap cycle arbitrates too, so back-to-back bursts see exactly one dead cycle
  always_comb begin
    state_next  = state;
    owner_next  = owner_q;
    last_d_next = last_d;
    addr_next   = addr_q;
    rw_next     = rw_q;
    case (state)
      ARB_IDLE, ARB_GAP: begin
        if (pick != ARB_OWNER_NONE) begin
          state_next  = ARB_GRANT;
          owner_next  = pick;
          last_d_next = (pick == ARB_OWNER_D);
          if (pick == ARB_OWNER_D) begin
            addr_next = d_mem_addr;
            rw_next   = d_mem_rw;
          end else begin
            addr_next = i_mem_addr;
            rw_next   = MEM_READ;
          end
        end else begin
          state_next = ARB_IDLE;
          owner_next = ARB_OWNER_NONE;
        end
      end
      ARB_GRANT: begin
        if (mem_last || !owner_enable) begin
          state_next = ARB_GAP;
          owner_next = ARB_OWNER_NONE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        owner_next = ARB_OWNER_NONE;
      end
    endcase
  end

  assign granted = (state == ARB_GRANT);
  assign own_i   = granted && (owner_q == ARB_OWNER_I);
  assign own_d   = granted && (owner_q == ARB_OWNER_D);

  assign owner      = owner_q;
  assign mem_enable = granted;
  assign mem_addr   = granted ? addr_q : '0;
  assign mem_rw     = granted ? rw_q : MEM_READ;
  assign mem_write  = own_d ? d_mem_write : '0;

  // Responses reach only the current owner; anything outside a grant is dropped
  assign i_mem_read       = own_i ? mem_read : '0;
  assign i_mem_read_valid = own_i && mem_read_valid;
  assign i_mem_last       = own_i && mem_last;
  assign d_mem_read       = own_d ? mem_read : '0;
  assign d_mem_read_valid = own_d && mem_read_valid;
  assign d_mem_write_req  = own_d && mem_write_req;
  assign d_mem_last       = own_d && mem_last;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a hand-driven BRAM response side.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk, rst_n;
  logic [31:0] i_mem_addr, d_mem_addr, d_mem_write;
  logic        i_mem_enable, d_mem_enable, d_mem_rw;
  logic [31:0] i_mem_read, d_mem_read;
  logic        i_mem_read_valid, i_mem_last;
  logic        d_mem_read_valid, d_mem_write_req, d_mem_last;
  logic [31:0] mem_addr, mem_write, mem_read;
  logic        mem_enable, mem_rw, mem_read_valid, mem_write_req, mem_last;
  logic [1:0]  owner;

  int testsRun = 0;
  int testsFailed = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_addr(i_mem_addr), .i_mem_enable(i_mem_enable), .i_mem_read(i_mem_read),
    .i_mem_read_valid(i_mem_read_valid), .i_mem_last(i_mem_last),
    .d_mem_addr(d_mem_addr), .d_mem_enable(d_mem_enable), .d_mem_rw(d_mem_rw),
    .d_mem_write(d_mem_write), .d_mem_read(d_mem_read), .d_mem_read_valid(d_mem_read_valid),
    .d_mem_write_req(d_mem_write_req), .d_mem_last(d_mem_last),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_write(mem_write),
    .mem_read(mem_read), .mem_read_valid(mem_read_valid), .mem_write_req(mem_write_req),
    .mem_last(mem_last), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ie, input logic [31:0] ia, input logic de,
                               input logic drw, input logic [31:0] da, input logic [31:0] dw);
    i_mem_enable = ie;
    i_mem_addr   = ia;
    d_mem_enable = de;
    d_mem_rw     = drw;
    d_mem_addr   = da;
    d_mem_write  = dw;
    #1;
  endtask

  task automatic setResp(input logic v, input logic [31:0] d, input logic l, input logic wr);
    mem_read_valid = v;
    mem_read       = d;
    mem_last       = l;
    mem_write_req  = wr;
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, MEM_READ, 0, 0);
    setResp(0, 0, 0, 0);
    step();
    step();
    checkOutput("rst_owner", {30'd0, owner}, 32'd0);
    checkOutput("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_i_valid", {31'd0, i_mem_read_valid}, 32'd0);
    rst_n = 1'b1;

    // Lone D read of 8 beats
    applyStimulus(0, 0, 1, MEM_READ, 32'h0100, 0);
    checkOutput("s1_pre_owner", {30'd0, owner}, 32'd0);
    step();
    checkOutput("s1_owner", {30'd0, owner}, 32'd2);
    checkOutput("s1_mem_enable", {31'd0, mem_enable}, 32'd1);
    checkOutput("s1_mem_rw", {31'd0, mem_rw}, {31'd0, MEM_READ});
    for (int n = 0; n < 8; n++) begin
      if (n == 3) applyStimulus(0, 0, 1, MEM_WRITE, 32'hBEEF, 0);
      setResp(1, 32'h1000 + n, n == 7, 0);
      checkOutput("s1_d_read", d_mem_read, 32'h1000 + n);
      checkOutput("s1_d_valid", {31'd0, d_mem_read_valid}, 32'd1);
      checkOutput("s1_i_valid", {31'd0, i_mem_read_valid}, 32'd0);
      checkOutput("s1_addr_held", mem_addr, 32'h0100);
      checkOutput("s1_rw_held", {31'd0, mem_rw}, {31'd0, MEM_READ});
      if (n == 7) checkOutput("s1_d_last", {31'd0, d_mem_last}, 32'd1);
      step();
    end
    applyStimulus(0, 0, 0, MEM_READ, 0, 0);
    setResp(1, 32'h5555, 0, 0);
    checkOutput("s1_gap_enable", {31'd0, mem_enable}, 32'd0);
    checkOutput("s1_gap_owner", {30'd0, owner}, 32'd0);
    checkOutput("s1_gap_d_valid", {31'd0, d_mem_read_valid}, 32'd0);
    checkOutput("s1_gap_d_read", d_mem_read, 32'd0);
    step();
    setResp(0, 0, 0, 0);
    checkOutput("s1_idle_enable", {31'd0, mem_enable}, 32'd0);

    // Both request from reset: D, then I, then D again; D write data never leaks into an I burst
    doReset();
    applyStimulus(1, 32'h3000, 1, MEM_READ, 32'h5000, 32'hDEAD);
    step();
    checkOutput("s2_first_owner", {30'd0, owner}, 32'd2);
    checkOutput("s2_first_addr", mem_addr, 32'h5000);
    setResp(1, 32'hA0, 0, 0);
    checkOutput("s2_d_valid", {31'd0, d_mem_read_valid}, 32'd1);
    checkOutput("s2_i_valid_off", {31'd0, i_mem_read_valid}, 32'd0);
    checkOutput("s2_i_read_off", i_mem_read, 32'd0);
    step();
    setResp(1, 32'hA1, 1, 0);
    checkOutput("s2_d_last", {31'd0, d_mem_last}, 32'd1);
    checkOutput("s2_i_last_off", {31'd0, i_mem_last}, 32'd0);
    step();
    setResp(0, 0, 0, 0);
    checkOutput("s2_gap1_enable", {31'd0, mem_enable}, 32'd0);
    checkOutput("s2_gap1_owner", {30'd0, owner}, 32'd0);
    step();
    checkOutput("s2_second_owner", {30'd0, owner}, 32'd1);
    checkOutput("s2_second_addr", mem_addr, 32'h3000);
    checkOutput("s2_i_rw", {31'd0, mem_rw}, {31'd0, MEM_READ});
    checkOutput("s2_no_dead", mem_write, 32'd0);
    setResp(1, 32'hB0, 0, 1);
    checkOutput("s2_i_read", i_mem_read, 32'hB0);
    checkOutput("s2_i_valid", {31'd0, i_mem_read_valid}, 32'd1);
    checkOutput("s2_d_valid_off", {31'd0, d_mem_read_valid}, 32'd0);
    checkOutput("s2_d_wreq_off", {31'd0, d_mem_write_req}, 32'd0);
    step();
    setResp(1, 32'hB1, 1, 0);
    checkOutput("s2_i_last", {31'd0, i_mem_last}, 32'd1);
    checkOutput("s2_d_last_off", {31'd0, d_mem_last}, 32'd0);
    step();
    setResp(0, 0, 0, 0);
    checkOutput("s2_gap2_enable", {31'd0, mem_enable}, 32'd0);
    checkOutput("s2_gap2_i_last", {31'd0, i_mem_last}, 32'd0);
    step();
    checkOutput("s2_third_owner", {30'd0, owner}, 32'd2);
    checkOutput("s2_d_wdata", mem_write, 32'hDEAD);
    applyStimulus(0, 0, 0, MEM_READ, 0, 0);
    step();
    step();
    checkOutput("s2_idle_owner", {30'd0, owner}, 32'd0);

    // D writeout then populate with enable held high
    applyStimulus(0, 0, 1, MEM_WRITE, 32'h0400, 32'h11110000);
    step();
    checkOutput("s3_wr_owner", {30'd0, owner}, 32'd2);
    checkOutput("s3_wr_rw", {31'd0, mem_rw}, {31'd0, MEM_WRITE});
    checkOutput("s3_wr_addr", mem_addr, 32'h0400);
    checkOutput("s3_wr_data", mem_write, 32'h11110000);
    setResp(0, 0, 0, 1);
    checkOutput("s3_wreq", {31'd0, d_mem_write_req}, 32'd1);
    step();
    applyStimulus(0, 0, 1, MEM_READ, 32'h2400, 32'h22220000);
    setResp(0, 0, 1, 1);
    checkOutput("s3_addr_held", mem_addr, 32'h0400);
    checkOutput("s3_rw_held", {31'd0, mem_rw}, {31'd0, MEM_WRITE});
    checkOutput("s3_wr_stream", mem_write, 32'h22220000);
    step();
    setResp(0, 0, 0, 0);
    checkOutput("s3_gap_enable", {31'd0, mem_enable}, 32'd0);
    step();
    checkOutput("s3_rd_enable", {31'd0, mem_enable}, 32'd1);
    checkOutput("s3_rd_rw", {31'd0, mem_rw}, {31'd0, MEM_READ});
    checkOutput("s3_rd_addr", mem_addr, 32'h2400);
    applyStimulus(0, 0, 0, MEM_READ, 0, 0);
    step();
    step();

    // I aborts at beat 3; a late response in the gap goes nowhere
    applyStimulus(1, 32'h6000, 0, MEM_READ, 0, 0);
    step();
    checkOutput("s5_owner", {30'd0, owner}, 32'd1);
    for (int n = 0; n < 4; n++) begin
      if (n == 3) applyStimulus(0, 0, 0, MEM_READ, 0, 0);
      setResp(1, 32'hC0 + n, 0, 0);
      checkOutput("s5_i_valid", {31'd0, i_mem_read_valid}, 32'd1);
      checkOutput("s5_enable", {31'd0, mem_enable}, 32'd1);
      step();
    end
    setResp(1, 32'h77, 0, 0);
    checkOutput("s5_gap_enable", {31'd0, mem_enable}, 32'd0);
    checkOutput("s5_gap_owner", {30'd0, owner}, 32'd0);
    checkOutput("s5_gap_i_valid", {31'd0, i_mem_read_valid}, 32'd0);
    checkOutput("s5_gap_d_valid", {31'd0, d_mem_read_valid}, 32'd0);
    checkOutput("s5_gap_i_read", i_mem_read, 32'd0);
    step();
    setResp(0, 0, 0, 0);
    checkOutput("s5_idle_enable", {31'd0, mem_enable}, 32'd0);

    // Async reset in the middle of a D burst, then D wins the first tie again
    applyStimulus(0, 0, 1, MEM_READ, 32'h8000, 0);
    step();
    checkOutput("s6_owner", {30'd0, owner}, 32'd2);
    for (int n = 0; n < 4; n++) begin
      setResp(1, 32'h1000 + n, 0, 0);
      step();
    end
    setResp(1, 32'h1004, 0, 0);
    applyStimulus(1, 32'h9000, 1, MEM_READ, 32'h8000, 0);
    checkOutput("s6_pre_d_valid", {31'd0, d_mem_read_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_enable", {31'd0, mem_enable}, 32'd0);
    checkOutput("s6_rst_owner", {30'd0, owner}, 32'd0);
    checkOutput("s6_rst_d_valid", {31'd0, d_mem_read_valid}, 32'd0);
    checkOutput("s6_rst_d_read", d_mem_read, 32'd0);
    checkOutput("s6_rst_addr", mem_addr, 32'd0);
    step();
    rst_n = 1'b1;
    setResp(0, 0, 0, 0);
    step();
    checkOutput("s6_post_owner", {30'd0, owner}, 32'd2);
    checkOutput("s6_post_addr", mem_addr, 32'h8000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
